ctrl_sequencer: RTL

Multi-cycle control sequencer, the successor to the single-cycle combinational control decoder. Accepts one instruction per valid/ready handshake, issues the same control-signal classes (A/R/load-store/branch/move), and runs load/store through a memory request/acknowledge handshake with timeout. Adds a halt/restart mode and a retired-instruction counter. Sits between the instruction fetch path and the datapath; drives register-file, ALU, memory and PC enables.

---
 rtl/ctrl_pkg.sv | 36 +++
 rtl/ctrl_decode.sv | 48 ++++
 rtl/ctrl_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control sequencer.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH,
    EXEC,
    MEM,
    WB,
    HALT
  } state_t;

  // Instruction class, taken from the top two opcode bits
  localparam logic [1:0] CLS_R  = 2'b00;
  localparam logic [1:0] CLS_LS = 2'b01;
  localparam logic [1:0] CLS_BR = 2'b10;
  localparam logic [1:0] CLS_MV = 2'b11;

  // ALU operation selects
  localparam logic [1:0] ALU_R    = 2'b00;  // R-type
  localparam logic [1:0] ALU_AF1  = 2'b01;  // A-type, Funct1=1
  localparam logic [1:0] ALU_AF0  = 2'b10;  // A-type, Funct1=0
  localparam logic [1:0] ALU_BR   = 2'b11;  // branch compare

  // Datapath control bundle
  typedef struct packed {
    logic       branch;
    logic       write_reg;
    logic       mem_write;
    logic       mem_read;
    logic       pc_en;
    logic [1:0] alu_op;
    logic [1:0] reg_c;
    logic [1:0] write_c;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational EXEC-state decode of a captured instruction.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [1:0]     i_cls,
  input  logic [OPW-3:0] i_sub,
  input  logic           i_funct1,
  input  logic           i_funct2,
  output ctrl_t          o_ctrl
);

  localparam int SUBW = OPW - 2;

  // Map class/sub/funct to EXEC controls; load/store never executes here
  always_comb begin
    o_ctrl = '0;
    case (i_cls)
      CLS_R: begin
        o_ctrl.pc_en = 1'b1;
        if (i_sub == '0) begin
          o_ctrl.reg_c     = 2'b00;
          o_ctrl.write_reg = 1'b1;
          o_ctrl.alu_op    = i_funct1 ? ALU_AF1 : ALU_AF0;
        end else begin
          o_ctrl.reg_c     = 2'b01;
          o_ctrl.alu_op    = ALU_R;
          o_ctrl.write_reg = (i_sub != SUBW'(6));
        end
      end
      CLS_BR: begin
        o_ctrl.pc_en  = 1'b1;
        o_ctrl.reg_c  = 2'b01;
        o_ctrl.branch = 1'b1;
        o_ctrl.alu_op = ALU_BR;
      end
      CLS_MV: begin
        o_ctrl.pc_en     = 1'b1;
        o_ctrl.reg_c     = {1'b1, ~i_funct2};
        o_ctrl.write_c   = {1'b1, i_funct2};
        o_ctrl.write_reg = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer: FETCH/EXEC/MEM/WB/HALT with memory timeout.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int OPW         = 5,
  parameter int CNTW        = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Start,
  input  logic            Instr_Valid,
  output logic            Instr_Ready,
  input  logic [OPW-1:0]  Opcode,
  input  logic            Funct1,
  input  logic            Funct2,
  input  logic            Mem_Ack,
  output logic            Branch,
  output logic            Write_Reg,
  output logic            Mem_Write,
  output logic            Mem_Read,
  output logic            Pc_En,
  output logic [1:0]      ALU_Op,
  output logic [1:0]      Reg_C,
  output logic [1:0]      Write_C,
  output logic            Halted,
  output logic            Mem_Err,
  output logic [CNTW-1:0] Instr_Count
);

  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t          r_state;
  logic [OPW-1:0]  r_op;
  logic            r_f1;
  logic            r_f2;
  logic [WW-1:0]   r_wait;
  logic [CNTW-1:0] r_cnt;
  logic            r_err;

  logic [1:0]      w_in_cls;
  logic [OPW-3:0]  w_in_sub;
  logic            w_in_halt;
  ctrl_t           w_dec;
  ctrl_t           w_out;

  assign w_in_cls  = Opcode[OPW-1:OPW-2];
  assign w_in_sub  = Opcode[OPW-3:0];
  assign w_in_halt = (w_in_cls == CLS_R) && (w_in_sub == '1);

  ctrl_decode #(.OPW(OPW)) u_decode (
    .i_cls    (r_op[OPW-1:OPW-2]),
    .i_sub    (r_op[OPW-3:0]),
    .i_funct1 (r_f1),
    .i_funct2 (r_f2),
    .o_ctrl   (w_dec)
  );

  // State machine, instruction register, wait/retire counters and error flag
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= FETCH;
      r_op    <= '0;
      r_f1    <= 1'b0;
      r_f2    <= 1'b0;
      r_wait  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (Instr_Valid) begin
            r_op   <= Opcode;
            r_f1   <= Funct1;
            r_f2   <= Funct2;
            r_wait <= '0;
            if (w_in_halt) begin
              r_state <= HALT;
              r_cnt   <= r_cnt + CNTW'(1);
            end else if (w_in_cls == CLS_LS) begin
              r_state <= MEM;
            end else begin
              r_state <= EXEC;
            end
          end
        end
        EXEC: begin
          r_state <= FETCH;
          r_cnt   <= r_cnt + CNTW'(1);
        end
        MEM: begin
          // Acknowledge takes priority over a timeout in the same cycle
          if (Mem_Ack) begin
            r_state <= WB;
          end else if (r_wait == WW'(MEM_TIMEOUT - 1)) begin
            r_state <= FETCH;
            r_err   <= 1'b1;
          end else begin
            r_wait  <= r_wait + WW'(1);
          end
        end
        WB: begin
          r_state <= FETCH;
          r_cnt   <= r_cnt + CNTW'(1);
        end
        HALT: begin
          if (Start) r_state <= FETCH;
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  // Moore output selection from state and captured instruction
  always_comb begin
    w_out = '0;
    case (r_state)
      EXEC: w_out = w_dec;
      MEM: begin
        w_out.reg_c     = 2'b10;
        w_out.write_c   = 2'b01;
        w_out.mem_write = r_f2;
        w_out.mem_read  = ~r_f2;
      end
      WB: begin
        w_out.reg_c     = 2'b10;
        w_out.write_c   = 2'b01;
        w_out.write_reg = ~r_f2;
        w_out.pc_en     = 1'b1;
      end
      default: w_out = '0;
    endcase
  end

  assign Branch      = w_out.branch;
  assign Write_Reg   = w_out.write_reg;
  assign Mem_Write   = w_out.mem_write;
  assign Mem_Read    = w_out.mem_read;
  assign Pc_En       = w_out.pc_en;
  assign ALU_Op      = w_out.alu_op;
  assign Reg_C       = w_out.reg_c;
  assign Write_C     = w_out.write_c;
  assign Instr_Ready = (r_state == FETCH);
  assign Halted      = (r_state == HALT);
  assign Mem_Err     = r_err;
  assign Instr_Count = r_cnt;

endmodule
